// File: rtl/control_sequencer.sv
// Microcode sequencer: walks fetch/execute T-states and decodes the opcode into one control word per clock.
// Define CTRL_COND_JUMP_EN to add flag_c/flag_z inputs and the JC (0x7) / JZ (0x8) conditional jumps.
module control_sequencer #(
  parameter int unsigned IR_W = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [IR_W-1:0] ir,
`ifdef CTRL_COND_JUMP_EN
  input  logic            flag_c,
  input  logic            flag_z,
`endif
  output logic [2:0]      t_state,
  output logic            halted,
  output logic            pc_en,
  output logic            pc_ld_n,
  output logic            pc_oe,
  output logic            mar_ld,
  output logic            ram_oe,
  output logic            ram_we,
  output logic            ir_ld,
  output logic            ir_oe,
  output logic            a_ld,
  output logic            a_oe,
  output logic            b_ld,
  output logic            alu_oe,
  output logic            alu_sub,
  output logic            flags_ld,
  output logic            out_ld
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  tstate_e    state_q, state_d;
  logic       halted_q, halted_d;
  logic [3:0] opcode;
  logic       unused_operand;

  assign opcode         = ir[IR_W-1 -: 4];
  assign unused_operand = ^ir[IR_W-5:0];
  assign t_state        = state_q;
  assign halted         = halted_q;

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      case (state_q)
        T0: state_d = T1;
        T1: state_d = T2;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = T3;
            OP_HLT: begin
              halted_d = 1'b1;
              state_d  = T0;
            end
            default: state_d = T0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_ADD, OP_SUB: state_d = T4;
            default:        state_d = T0;
          endcase
        end
        // T4 always ends the instruction; unused encodings recover to T0 here too
        default: state_d = T0;
      endcase
    end
  end

  always_comb begin
    pc_en    = 1'b0;
    pc_ld_n  = 1'b1;
    pc_oe    = 1'b0;
    mar_ld   = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    ir_ld    = 1'b0;
    ir_oe    = 1'b0;
    a_ld     = 1'b0;
    a_oe     = 1'b0;
    b_ld     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    flags_ld = 1'b0;
    out_ld   = 1'b0;
    if (run && !halted_q && !clr) begin
      case (state_q)
        T0: begin
          pc_oe  = 1'b1;
          mar_ld = 1'b1;
        end
        T1: begin
          ram_oe = 1'b1;
          ir_ld  = 1'b1;
          pc_en  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oe  = 1'b1;
              mar_ld = 1'b1;
            end
            OP_LDI: begin
              ir_oe = 1'b1;
              a_ld  = 1'b1;
            end
            OP_JMP: begin
              ir_oe   = 1'b1;
              pc_ld_n = 1'b0;
            end
`ifdef CTRL_COND_JUMP_EN
            OP_JC: begin
              ir_oe   = flag_c;
              pc_ld_n = !flag_c;
            end
            OP_JZ: begin
              ir_oe   = flag_z;
              pc_ld_n = !flag_z;
            end
`endif
            OP_OUT: begin
              a_oe   = 1'b1;
              out_ld = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_oe = 1'b1;
              a_ld   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oe = 1'b1;
              b_ld   = 1'b1;
            end
            OP_STA: begin
              a_oe   = 1'b1;
              ram_we = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe   = 1'b1;
            a_ld     = 1'b1;
            flags_ld = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit CPU. Sits directly upstream of the program counter.
- Steps through fetch/execute T-states and decodes the instruction register opcode.
- Emits one control word per clock: PC count enable, PC load (active-low), bus output enables and register loads.
- Registers and the PC act on the control word at the next rising clk.

Parameters:
- IR_W, 8, instruction register width. Opcode = ir[IR_W-1 -: 4]; operand = ir[3:0] (driven on bus by ir_oe).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- clr  input  1  reset, synchronous, active-high
- run  input  1  1 = advance one T-state per clk; 0 = hold state, all controls deasserted
- ir  input  IR_W  current instruction register contents
- t_state  output  3  current T-state, 0..4
- halted  output  1  sticky halt flag
- pc_en  output  1  PC count enable; drives p_en and t_en
- pc_ld_n  output  1  PC load, active-low; drives ld_n
- pc_oe  output  1  PC to bus
- mar_ld  output  1  memory address register load
- ram_oe  output  1  RAM to bus
- ram_we  output  1  RAM write
- ir_ld  output  1  instruction register load
- ir_oe  output  1  IR operand to bus
- a_ld  output  1  A register load
- a_oe  output  1  A register to bus
- b_ld  output  1  B register load
- alu_oe  output  1  ALU result to bus
- alu_sub  output  1  ALU subtract select
- flags_ld  output  1  flags register load
- out_ld  output  1  output register load

Behaviour:
- Reset (clr=1 at posedge): t_state=0, halted=0. While clr=1, all controls are 0 and pc_ld_n=1. clr overrides run and halted, including mid-instruction.
- Control outputs are combinational from t_state, ir and run/halted. They are forced inactive (0, pc_ld_n=1) when run=0 or halted=1.
- At most one *_oe is asserted in any cycle.
- State advances only when run=1 and halted=0. With run=0, t_state holds.
- T0: pc_oe, mar_ld.
- T1: ram_oe, ir_ld, pc_en.
- T2, by opcode:
  - LDA 0x0, ADD 0x1, SUB 0x2, STA 0x4: ir_oe, mar_ld.
  - LDI 0x5: ir_oe, a_ld.
  - JMP 0x6: ir_oe, pc_ld_n=0.
  - OUT 0xE: a_oe, out_ld.
  - HLT 0xF: no controls; halted set at this clk.
  - Any other opcode: NOP, no controls.
- T3: LDA: ram_oe, a_ld. ADD/SUB: ram_oe, b_ld. STA: a_oe, ram_we.
- T4: ADD: alu_oe, a_ld, flags_ld. SUB: same plus alu_sub.
- Variable-length instructions: after an instruction's last active step, next state is T0.
  - LDI, JMP, OUT, NOP end at T2 (3 cycles).
  - LDA, STA end at T3 (4 cycles).
  - ADD, SUB end at T4 (5 cycles).
- HLT: on the T2 clk, halted<=1 and t_state<=0. Stays halted until clr. The PC already incremented in T1, so it points past HLT.
- run deasserted mid-instruction: freezes at the current T-state. Resumes the same step when run returns to 1.
- t_state never exceeds 4. Any illegal encoding returns to 0 on the next advancing clk.
- The ir value is used only in T2..T4 (IR loaded at end of T1).

Optional Feature:
- Macro CTRL_COND_JUMP_EN.
- Defined:
  - Adds inputs flag_c and flag_z (1 bit each).
  - JC 0x7: in T2, if flag_c=1 assert ir_oe and pc_ld_n=0, else no controls.
  - JZ 0x8: same, conditioned on flag_z.
  - Both end at T2.
- Undefined: ports absent; 0x7 and 0x8 decode as NOP.

Test Plan:
- Reset/fetch: clr=1 for 2 clks, then run=1, ir=0x5_3 (LDI 3) -> t_state 0,1,2,0. T0 pc_oe+mar_ld; T1 ram_oe+ir_ld+pc_en; T2 ir_oe+a_ld; pc_ld_n=1 throughout.
- ADD: ir=0x1A -> T2 ir_oe+mar_ld; T3 ram_oe+b_ld; T4 alu_oe+a_ld+flags_ld with alu_sub=0; next t_state=0. SUB 0x2A -> same with alu_sub=1 in T4.
- JMP: ir=0x69 -> T2 pc_ld_n=0 with ir_oe=1 for exactly one cycle; pc_en=0 in that cycle.
- Halt: ir=0xF0 -> after T2 clk halted=1, t_state=0, all controls 0 for 10 further clks. clr=1 clears halted.
- run/clr mid-op: drop run in T3 of LDA 0x07 -> t_state stays 3 and controls are 0. Raise run -> ram_oe+a_ld then T0. Assert clr in T4 of ADD -> next t_state=0, controls 0.
- CTRL_COND_JUMP_EN: JZ 0x84 with flag_z=0 -> no pc_ld_n pulse, back to T0 after T2. With flag_z=1 -> pc_ld_n=0 in T2. Without the macro, 0x84 acts as NOP.
